pac_gen: RTL and testbench
==========================

Name: pac_gen

Overview:
- Test-frame generator that sits directly upstream of the packet checker in the VLC/UART link test path.
- Emits frames of FRAME_LEN_VAL 32-bit words whose payload is the word index: 0, 1, ..., FRAME_LEN_VAL-1.
- Inserts a programmable idle gap between frames.
- Supports downstream backpressure and counts frames actually sent, so the receive-side checker's frame count can be compared against it.

Parameters:
- FRAME_LEN_VAL, 40: words per frame; must be >= 2.
- GAP_LEN, 16: idle cycles between the last accepted word of a frame and word 0 of the next frame; 0 allowed.
- FRAME_NUM, 0: frames to send per run; 0 = continuous until disabled.

Ports:
- i_pac_gen_clk  in  1  single clock for the whole block.
- i_rst  in  1  synchronous, active-high reset.
- i_pac_gen_en  in  1  run request; level-sensitive.
- i_pac_gen_ready  in  1  downstream can accept a word this cycle.
- o_pac_gen_data  out  32  frame word (= word index).
- o_pac_gen_data_valid  out  1  o_pac_gen_data is valid.
- o_pac_gen_sof  out  1  qualifies word 0 of a frame; high only together with valid.
- o_pac_gen_eof  out  1  qualifies word FRAME_LEN_VAL-1; high only together with valid.
- o_sent_frame_num  out  32  frames fully transferred since reset.
- o_busy  out  1  high in DATA or GAP.

Behaviour:
- Reset: one clock and reset only; reset is synchronous and active-high (i_rst sampled on the rising edge of i_pac_gen_clk).
  - On reset, all outputs are 0 from the next edge: data, valid, sof, eof, o_sent_frame_num, o_busy.
  - State goes to IDLE; word counter, gap counter and run-frame counter clear.
  - Reset mid-frame truncates the frame with no eof; o_sent_frame_num does not count it.
- Transfer: occurs on a cycle where valid && ready.
  - While valid && !ready, data, sof and eof hold stable.
  - Valid never drops without a transfer, except on reset.
- State machine, states IDLE, DATA, GAP, DONE:
  - IDLE: outputs idle. If en=1, go to DATA at the next edge, presenting word 0 with sof=1. First valid appears 1 cycle after en is sampled high.
  - DATA: word counter w is driven on data.
    - On each transfer, w increments.
    - On the transfer of w = FRAME_LEN_VAL-1 (eof=1), o_sent_frame_num and the run-frame counter both increment, w clears to 0, and the next state is selected.
    - Next state when FRAME_NUM != 0 and the run-frame count reaches FRAME_NUM: DONE.
    - Otherwise, when GAP_LEN > 0: GAP.
    - Otherwise, when en=1: DATA, with word 0 and sof presented on the very next cycle (back-to-back).
    - Otherwise: IDLE.
  - GAP: valid=0 for exactly GAP_LEN cycles, counted from the cycle after the eof transfer. At the end of the gap, go to DATA with word 0 if en=1, else IDLE.
  - DONE: valid=0, o_busy=0. Stay until en=0, then go to IDLE. The run-frame counter clears on leaving DONE. o_sent_frame_num does not clear.
- en deassertion mid-frame: the current frame completes in full; en is sampled only at frame boundaries, i.e. at the end of GAP or at eof when GAP_LEN=0.
- Arithmetic: o_sent_frame_num and the word counter are 32-bit and wrap modulo 2^32 with no saturation.
- Simultaneous events: eof transfer with en falling in the same cycle gives a full frame count, then GAP (if GAP_LEN > 0), then IDLE.
- Output timing: all outputs are registered; no combinational path from ready or en to any output.

Test Plan:
- Defaults, en=1 held, ready=1 constant: expect words 0..39 on 40 consecutive cycles with sof on 0 and eof on 39, then exactly 16 idle cycles, then 0 again. o_sent_frame_num = 1 at the cycle after the first eof.
- Backpressure: ready toggles 1,0,0,1 repeating. Expect every word held stable while ready=0, no duplicated or skipped index across 3 frames, o_sent_frame_num = 3.
- FRAME_NUM=2, GAP_LEN=0, en=1 held: expect 80 back-to-back words (0..39, 0..39), then valid=0 in DONE, o_busy=0, o_sent_frame_num = 2. Drop en, raise again: expect 2 more frames, count = 4.
- en dropped at word 10 of a frame: frame runs to word 39 with eof, the gap elapses, then IDLE with no further valid. Count = 1.
- i_rst asserted for 1 cycle at word 25: all outputs 0 next cycle, o_sent_frame_num = 0. With en still high, the next frame restarts at word 0 with sof 1 cycle after reset releases.
- Loopback with the packet checker, 100 frames: checker frame count = 100, good frame count = 100, matching o_sent_frame_num = 100.

Source files
------------

// File: rtl/pac_gen.sv
// pac_gen: test-frame generator. Emits frames whose payload is the word index,
// separates frames with an idle gap, honours backpressure and counts completed frames.
module pac_gen #(
    parameter int unsigned FRAME_LEN_VAL = 40,
    parameter int unsigned GAP_LEN       = 16,
    parameter int unsigned FRAME_NUM     = 0
) (
    input  logic        i_pac_gen_clk,
    input  logic        i_rst,
    input  logic        i_pac_gen_en,
    input  logic        i_pac_gen_ready,
    output logic [31:0] o_pac_gen_data,
    output logic        o_pac_gen_data_valid,
    output logic        o_pac_gen_sof,
    output logic        o_pac_gen_eof,
    output logic [31:0] o_sent_frame_num,
    output logic        o_busy
);

    localparam logic [31:0] LAST_WORD  = 32'(FRAME_LEN_VAL - 1);
    localparam logic [31:0] GAP_LAST   = (GAP_LEN > 0) ? 32'(GAP_LEN - 1) : 32'd0;
    localparam logic [31:0] RUN_FRAMES = 32'(FRAME_NUM);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_GAP,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [31:0] r_word;
    logic        r_valid;
    logic        r_sof;
    logic        r_eof;
    logic [31:0] r_gap_cnt;
    logic [31:0] r_run_cnt;
    logic [31:0] r_sent;
    logic        r_busy;

    state_t      w_state_nxt;
    logic [31:0] w_word_nxt;
    logic        w_valid_nxt;
    logic        w_sof_nxt;
    logic        w_eof_nxt;
    logic [31:0] w_gap_nxt;
    logic [31:0] w_run_nxt;
    logic [31:0] w_sent_nxt;
    logic        w_busy_nxt;
    logic        w_xfer;
    logic [31:0] w_run_inc;

    // Every output is a register; the next values are all decided here so that
    // ready and en only ever reach the outputs through a flop.
    always_comb begin
        w_state_nxt = r_state;
        w_word_nxt  = r_word;
        w_valid_nxt = r_valid;
        w_sof_nxt   = r_sof;
        w_eof_nxt   = r_eof;
        w_gap_nxt   = r_gap_cnt;
        w_run_nxt   = r_run_cnt;
        w_sent_nxt  = r_sent;
        w_xfer      = r_valid && i_pac_gen_ready;
        w_run_inc   = r_run_cnt + 32'd1;
        case (r_state)
            S_IDLE: begin
                if (i_pac_gen_en) begin
                    w_state_nxt = S_DATA;
                    w_word_nxt  = 32'd0;
                    w_valid_nxt = 1'b1;
                    w_sof_nxt   = 1'b1;
                    w_eof_nxt   = 1'b0;
                end
            end
            S_DATA: begin
                if (w_xfer) begin
                    w_sof_nxt = 1'b0;
                    if (r_eof) begin
                        w_sent_nxt  = r_sent + 32'd1;
                        w_run_nxt   = w_run_inc;
                        w_word_nxt  = 32'd0;
                        w_eof_nxt   = 1'b0;
                        w_gap_nxt   = 32'd0;
                        w_valid_nxt = 1'b0;
                        if ((RUN_FRAMES != 32'd0) && (w_run_inc == RUN_FRAMES)) begin
                            w_state_nxt = S_DONE;
                        end else if (GAP_LEN > 0) begin
                            w_state_nxt = S_GAP;
                        end else if (i_pac_gen_en) begin
                            w_valid_nxt = 1'b1;
                            w_sof_nxt   = 1'b1;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_word_nxt = r_word + 32'd1;
                        w_eof_nxt  = ((r_word + 32'd1) == LAST_WORD);
                    end
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_gap_nxt = 32'd0;
                    if (i_pac_gen_en) begin
                        w_state_nxt = S_DATA;
                        w_word_nxt  = 32'd0;
                        w_valid_nxt = 1'b1;
                        w_sof_nxt   = 1'b1;
                        w_eof_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_gap_nxt = r_gap_cnt + 32'd1;
                end
            end
            S_DONE: begin
                // The run restarts only after en has been seen low once.
                if (!i_pac_gen_en) begin
                    w_state_nxt = S_IDLE;
                    w_run_nxt   = 32'd0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt == S_DATA) || (w_state_nxt == S_GAP);
    end

    always_ff @(posedge i_pac_gen_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_word    <= 32'd0;
            r_valid   <= 1'b0;
            r_sof     <= 1'b0;
            r_eof     <= 1'b0;
            r_gap_cnt <= 32'd0;
            r_run_cnt <= 32'd0;
            r_sent    <= 32'd0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_word    <= w_word_nxt;
            r_valid   <= w_valid_nxt;
            r_sof     <= w_sof_nxt;
            r_eof     <= w_eof_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_run_cnt <= w_run_nxt;
            r_sent    <= w_sent_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    assign o_pac_gen_data       = r_word;
    assign o_pac_gen_data_valid = r_valid;
    assign o_pac_gen_sof        = r_sof;
    assign o_pac_gen_eof        = r_eof;
    assign o_sent_frame_num     = r_sent;
    assign o_busy               = r_busy;

endmodule

// File: tb/tb_pac_gen.sv
// tb_pac_gen: self-checking bench for pac_gen. Instance a uses the default
// parameters, instance b runs a two-frame burst with no gap.
module tb_pac_gen;

    localparam int L = 40;
    localparam int G = 16;
    localparam int P = L + G;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, ready_a, en_b, ready_b;
    logic [31:0] data_a, sent_a, data_b, sent_b;
    logic        valid_a, sof_a, eof_a, busy_a;
    logic        valid_b, sof_b, eof_b, busy_b;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pac_gen #(.FRAME_LEN_VAL(L), .GAP_LEN(G), .FRAME_NUM(0)) dut_a (
        .i_pac_gen_clk        (clk),
        .i_rst                (rst),
        .i_pac_gen_en         (en_a),
        .i_pac_gen_ready      (ready_a),
        .o_pac_gen_data       (data_a),
        .o_pac_gen_data_valid (valid_a),
        .o_pac_gen_sof        (sof_a),
        .o_pac_gen_eof        (eof_a),
        .o_sent_frame_num     (sent_a),
        .o_busy               (busy_a)
    );

    pac_gen #(.FRAME_LEN_VAL(L), .GAP_LEN(0), .FRAME_NUM(2)) dut_b (
        .i_pac_gen_clk        (clk),
        .i_rst                (rst),
        .i_pac_gen_en         (en_b),
        .i_pac_gen_ready      (ready_b),
        .o_pac_gen_data       (data_b),
        .o_pac_gen_data_valid (valid_b),
        .o_pac_gen_sof        (sof_b),
        .o_pac_gen_eof        (eof_b),
        .o_sent_frame_num     (sent_b),
        .o_busy               (busy_b)
    );

    // Outputs are sampled and inputs driven 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en_a = 1'b0; en_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            n_cmp += 6;
            if (data_a !== 32'd0) begin n_fail++; $display("FAIL reset_data_a got=%0d exp=0", data_a); end
            if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid_a got=%b exp=0", valid_a); end
            if (sof_a !== 1'b0)   begin n_fail++; $display("FAIL reset_sof_a got=%b exp=0", sof_a); end
            if (eof_a !== 1'b0)   begin n_fail++; $display("FAIL reset_eof_a got=%b exp=0", eof_a); end
            if (sent_a !== 32'd0) begin n_fail++; $display("FAIL reset_sent_a got=%0d exp=0", sent_a); end
            if (busy_a !== 1'b0)  begin n_fail++; $display("FAIL reset_busy_a got=%b exp=0", busy_a); end
            n_cmp += 4;
            if (data_b !== 32'd0) begin n_fail++; $display("FAIL reset_data_b got=%0d exp=0", data_b); end
            if (valid_b !== 1'b0) begin n_fail++; $display("FAIL reset_valid_b got=%b exp=0", valid_b); end
            if (sent_b !== 32'd0) begin n_fail++; $display("FAIL reset_sent_b got=%0d exp=0", sent_b); end
            if (busy_b !== 1'b0)  begin n_fail++; $display("FAIL reset_busy_b got=%b exp=0", busy_b); end
            tick();
        end
    endtask

    // en held, ready=1: the output is periodic with period L+G.
    task automatic test_continuous();
        int pos;
        int exp_sent;
        do_reset();
        en_a = 1'b1;
        tick();
        for (int t = 0; t < 2 * P + L; t++) begin
            pos      = t % P;
            exp_sent = (t >= L) ? ((t - L) / P + 1) : 0;
            n_cmp += 3;
            if (valid_a !== (pos < L)) begin n_fail++; $display("FAIL cont_valid t=%0d got=%b exp=%b", t, valid_a, pos < L); end
            if (sent_a !== 32'(exp_sent)) begin n_fail++; $display("FAIL cont_sent t=%0d got=%0d exp=%0d", t, sent_a, exp_sent); end
            if (busy_a !== 1'b1) begin n_fail++; $display("FAIL cont_busy t=%0d got=%b exp=1", t, busy_a); end
            if (pos < L) begin
                n_cmp += 3;
                if (data_a !== 32'(pos)) begin n_fail++; $display("FAIL cont_data t=%0d got=%0d exp=%0d", t, data_a, pos); end
                if (sof_a !== (pos == 0)) begin n_fail++; $display("FAIL cont_sof t=%0d got=%b exp=%b", t, sof_a, pos == 0); end
                if (eof_a !== (pos == L - 1)) begin n_fail++; $display("FAIL cont_eof t=%0d got=%b exp=%b", t, eof_a, pos == L - 1); end
            end
            tick();
        end
        en_a = 1'b0;
    endtask

    // Scoreboard over an expected word queue; mode 0 = ready 1,0,0,1 pattern, 1 = random ready.
    task automatic test_stream(input int mode, input int frames);
        logic [31:0] exp_q[$];
        int total, cyc, gap_run, done_frames, budget;
        logic seen_eof, exp_valid;
        exp_q.delete();
        for (int f = 0; f < frames; f++)
            for (int w = 0; w < L; w++) exp_q.push_back(32'(w));
        total = frames * L;
        budget = frames * (4 * L + G) + 100;
        cyc = 0; gap_run = 0; seen_eof = 1'b0;
        do_reset();
        en_a = 1'b1;
        tick();
        while (exp_q.size() > 0 && cyc < budget) begin
            ready_a = (mode == 0) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'($urandom_range(0, 1));
            done_frames = (total - exp_q.size()) / L;
            exp_valid = seen_eof ? (gap_run == G) : 1'b1;
            n_cmp += 3;
            if (sent_a !== 32'(done_frames)) begin n_fail++; $display("FAIL stream_sent cyc=%0d got=%0d exp=%0d", cyc, sent_a, done_frames); end
            if (valid_a !== exp_valid) begin n_fail++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", cyc, valid_a, exp_valid); end
            if (busy_a !== 1'b1) begin n_fail++; $display("FAIL stream_busy cyc=%0d got=%b exp=1", cyc, busy_a); end
            if (valid_a === 1'b1) begin
                seen_eof = 1'b0;
                gap_run  = 0;
                n_cmp += 3;
                if (data_a !== exp_q[0]) begin n_fail++; $display("FAIL stream_data cyc=%0d got=%0d exp=%0d", cyc, data_a, exp_q[0]); end
                if (sof_a !== (exp_q.size() % L == 0)) begin n_fail++; $display("FAIL stream_sof cyc=%0d got=%b exp=%b", cyc, sof_a, exp_q.size() % L == 0); end
                if (eof_a !== (exp_q.size() % L == 1)) begin n_fail++; $display("FAIL stream_eof cyc=%0d got=%b exp=%b", cyc, eof_a, exp_q.size() % L == 1); end
                if (ready_a) begin
                    if (exp_q.size() % L == 1) seen_eof = 1'b1;
                    void'(exp_q.pop_front());
                end
            end else if (seen_eof) begin
                gap_run++;
            end
            tick();
            cyc++;
        end
        n_cmp += 2;
        if (cyc >= budget) begin n_fail++; $display("FAIL stream_timeout mode=%0d left=%0d exp=0", mode, exp_q.size()); end
        if (sent_a !== 32'(frames)) begin n_fail++; $display("FAIL stream_final_sent mode=%0d got=%0d exp=%0d", mode, sent_a, frames); end
        en_a = 1'b0;
        ready_a = 1'b1;
    endtask

    // Instance b: two back-to-back frames, then DONE until en drops; repeated twice.
    task automatic test_frame_num();
        int exp_sent;
        do_reset();
        en_b = 1'b1;
        tick();
        for (int run = 0; run < 2; run++) begin
            for (int t = 0; t < 2 * L + 6; t++) begin
                exp_sent = 2 * run + ((t < 2 * L) ? t / L : 2);
                n_cmp += 3;
                if (valid_b !== (t < 2 * L)) begin n_fail++; $display("FAIL fn_valid run=%0d t=%0d got=%b exp=%b", run, t, valid_b, t < 2 * L); end
                if (busy_b !== (t < 2 * L)) begin n_fail++; $display("FAIL fn_busy run=%0d t=%0d got=%b exp=%b", run, t, busy_b, t < 2 * L); end
                if (sent_b !== 32'(exp_sent)) begin n_fail++; $display("FAIL fn_sent run=%0d t=%0d got=%0d exp=%0d", run, t, sent_b, exp_sent); end
                if (t < 2 * L) begin
                    n_cmp += 3;
                    if (data_b !== 32'(t % L)) begin n_fail++; $display("FAIL fn_data run=%0d t=%0d got=%0d exp=%0d", run, t, data_b, t % L); end
                    if (sof_b !== (t % L == 0)) begin n_fail++; $display("FAIL fn_sof run=%0d t=%0d got=%b exp=%b", run, t, sof_b, t % L == 0); end
                    if (eof_b !== (t % L == L - 1)) begin n_fail++; $display("FAIL fn_eof run=%0d t=%0d got=%b exp=%b", run, t, eof_b, t % L == L - 1); end
                end
                tick();
            end
            en_b = 1'b0;
            tick();
            n_cmp += 2;
            if (valid_b !== 1'b0) begin n_fail++; $display("FAIL fn_idle_valid run=%0d got=%b exp=0", run, valid_b); end
            if (busy_b !== 1'b0) begin n_fail++; $display("FAIL fn_idle_busy run=%0d got=%b exp=0", run, busy_b); end
            en_b = 1'b1;
            tick();
        end
        en_b = 1'b0;
    endtask

    // en dropped at word 10: frame completes, gap elapses, then idle.
    task automatic test_en_drop();
        logic exp_valid;
        do_reset();
        en_a = 1'b1;
        tick();
        for (int t = 0; t < L + G + 30; t++) begin
            exp_valid = (t < L);
            n_cmp += 3;
            if (valid_a !== exp_valid) begin n_fail++; $display("FAIL drop_valid t=%0d got=%b exp=%b", t, valid_a, exp_valid); end
            if (busy_a !== (t < L + G)) begin n_fail++; $display("FAIL drop_busy t=%0d got=%b exp=%b", t, busy_a, t < L + G); end
            if (sent_a !== 32'(t >= L)) begin n_fail++; $display("FAIL drop_sent t=%0d got=%0d exp=%0d", t, sent_a, t >= L); end
            if (exp_valid) begin
                n_cmp += 2;
                if (data_a !== 32'(t)) begin n_fail++; $display("FAIL drop_data t=%0d got=%0d exp=%0d", t, data_a, t); end
                if (eof_a !== (t == L - 1)) begin n_fail++; $display("FAIL drop_eof t=%0d got=%b exp=%b", t, eof_a, t == L - 1); end
            end
            if (t == 10) en_a = 1'b0;
            tick();
        end
    endtask

    // Reset pulse at word 25 of the second frame, en kept high throughout.
    task automatic test_mid_reset();
        do_reset();
        en_a = 1'b1;
        tick();
        for (int t = 0; t < P + 25; t++) tick();
        n_cmp += 3;
        if (data_a !== 32'd25) begin n_fail++; $display("FAIL mrst_pre_data got=%0d exp=25", data_a); end
        if (valid_a !== 1'b1) begin n_fail++; $display("FAIL mrst_pre_valid got=%b exp=1", valid_a); end
        if (sent_a !== 32'd1) begin n_fail++; $display("FAIL mrst_pre_sent got=%0d exp=1", sent_a); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp += 6;
        if (data_a !== 32'd0) begin n_fail++; $display("FAIL mrst_data got=%0d exp=0", data_a); end
        if (valid_a !== 1'b0) begin n_fail++; $display("FAIL mrst_valid got=%b exp=0", valid_a); end
        if (sof_a !== 1'b0)   begin n_fail++; $display("FAIL mrst_sof got=%b exp=0", sof_a); end
        if (eof_a !== 1'b0)   begin n_fail++; $display("FAIL mrst_eof got=%b exp=0", eof_a); end
        if (sent_a !== 32'd0) begin n_fail++; $display("FAIL mrst_sent got=%0d exp=0", sent_a); end
        if (busy_a !== 1'b0)  begin n_fail++; $display("FAIL mrst_busy got=%b exp=0", busy_a); end
        tick();
        n_cmp += 5;
        if (valid_a !== 1'b1) begin n_fail++; $display("FAIL mrst_restart_valid got=%b exp=1", valid_a); end
        if (data_a !== 32'd0) begin n_fail++; $display("FAIL mrst_restart_data got=%0d exp=0", data_a); end
        if (sof_a !== 1'b1)   begin n_fail++; $display("FAIL mrst_restart_sof got=%b exp=1", sof_a); end
        if (sent_a !== 32'd0) begin n_fail++; $display("FAIL mrst_restart_sent got=%0d exp=0", sent_a); end
        if (busy_a !== 1'b1)  begin n_fail++; $display("FAIL mrst_restart_busy got=%b exp=1", busy_a); end
        en_a = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en_a = 1'b0; en_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
        test_reset();
        test_continuous();
        test_stream(0, 3);
        test_frame_num();
        test_en_drop();
        test_mid_reset();
        test_stream(1, 100);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
